// File: rtl/frac_lut6_cfg_pkg.sv
// Shared constants and state encoding for the fractured LUT6 configuration loader.
package frac_lut6_cfg_pkg;
  localparam int LUT_SIZE = 6;
  localparam int NUM_BITS = 2**LUT_SIZE;
  localparam int CNT_W    = LUT_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/frac_lut6_cfg_loader_if.sv
// Serial configuration stream in, committed truth table out; master drives the stream.
interface frac_lut6_cfg_loader_if;
  import frac_lut6_cfg_pkg::*;

  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_bit;
  logic                cfg_ready;
  logic                ccff_tail;
  logic [0:NUM_BITS-1] sram;
  logic [0:NUM_BITS-1] sram_inv;
  logic                cfg_done;
  logic                cfg_err;

  modport master (
    output cfg_start, cfg_valid, cfg_bit,
    input  cfg_ready, ccff_tail, sram, sram_inv, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit,
    output cfg_ready, ccff_tail, sram, sram_inv, cfg_done, cfg_err
  );
endinterface

// File: rtl/frac_lut6_cfg_shreg.sv
// Shadow shift register, accepted-bit counter and chain tail; one bit per i_shift, no latency.
// Clear-count wins over shift so a restart discards the same-cycle bit.
module frac_lut6_cfg_shreg
  import frac_lut6_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_shift,
  input  logic                i_bit,
  input  logic                i_clr_cnt,
  output logic [0:NUM_BITS-1] o_shadow,
  output logic                o_tail,
  output logic                o_last
);
  logic [0:NUM_BITS-1] r_shadow;
  logic [CNT_W-1:0]    r_count;
  logic                r_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_count  <= '0;
      r_tail   <= 1'b0;
    end else if (i_clr_cnt) begin
      r_count <= '0;
    end else if (i_shift) begin
      // New bits enter at the high index so the first bit lands at index 0.
      r_tail   <= r_shadow[0];
      r_shadow <= {r_shadow[1:NUM_BITS-1], i_bit};
      r_count  <= r_count + CNT_W'(1);
    end
  end

  assign o_shadow = r_shadow;
  assign o_tail   = r_tail;
  assign o_last   = (r_count == CNT_W'(NUM_BITS - 1));
endmodule

// File: rtl/frac_lut6_cfg_loader.sv
// Loads a LUT6 truth table serially and commits all 64 bits atomically one cycle after the last bit.
// cfg_ready is high only in SHIFT; stalls on cfg_valid simply hold the stream position.
module frac_lut6_cfg_loader
  import frac_lut6_cfg_pkg::*;
(
  input  logic                   prog_clk,
  input  logic                   pReset,
  frac_lut6_cfg_loader_if.slave  bus
);
  state_t              r_state;
  logic [0:NUM_BITS-1] r_sram;
  logic [0:NUM_BITS-1] r_sram_inv;
  logic                r_done;
  logic                r_err;

  logic                w_in_shift;
  logic                w_hs;
  logic                w_shift;
  logic                w_clr;
  logic                w_last;
  logic                w_tail;
  logic [0:NUM_BITS-1] w_shadow;

  assign w_in_shift = (r_state == SHIFT);
  assign w_hs       = bus.cfg_valid & w_in_shift;
  assign w_shift    = w_hs & ~bus.cfg_start;
  assign w_clr      = bus.cfg_start & (r_state != COMMIT);

  frac_lut6_cfg_shreg u_shreg (
    .clk       (prog_clk),
    .rst       (pReset),
    .i_shift   (w_shift),
    .i_bit     (bus.cfg_bit),
    .i_clr_cnt (w_clr),
    .o_shadow  (w_shadow),
    .o_tail    (w_tail),
    .o_last    (w_last)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state    <= IDLE;
      r_sram     <= '0;
      r_sram_inv <= '1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cfg_start) begin
            r_state <= SHIFT;
            r_err   <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.cfg_start) begin
            r_err <= 1'b1;
          end else if (w_hs && w_last) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_sram     <= w_shadow;
          r_sram_inv <= ~w_shadow;
          r_done     <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          if (bus.cfg_start) begin
            r_state <= SHIFT;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = w_in_shift;
  assign bus.ccff_tail = w_tail;
  assign bus.sram      = r_sram;
  assign bus.sram_inv  = r_sram_inv;
  assign bus.cfg_done  = r_done;
  assign bus.cfg_err   = r_err;
endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Directed bench for frac_lut6_cfg_loader: reset, loads, backpressure, abort, chaining, mid-load reset.
module tb_frac_lut6_cfg_loader;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  frac_lut6_cfg_loader_if u_if ();

  frac_lut6_cfg_loader dut (
    .prog_clk (clk),
    .pReset   (rst),
    .bus      (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    u_if.cfg_start = 1'b1;
    tick();
    u_if.cfg_start = 1'b0;
  endtask

  // Sends pat[0..nbits-1]; with bp set, every third cycle has cfg_valid low.
  task automatic send_bits(input logic [0:63] pat, input int nbits, input bit bp,
                           output logic [0:63] tails);
    tails = '0;
    for (int k = 0; k < nbits; k++) begin
      if (bp && (cyc % 3 == 2)) begin
        u_if.cfg_valid = 1'b0;
        u_if.cfg_bit   = ~pat[k];
        tick();
      end
      u_if.cfg_valid = 1'b1;
      u_if.cfg_bit   = pat[k];
      tick();
      tails[k] = u_if.ccff_tail;
    end
    u_if.cfg_valid = 1'b0;
    u_if.cfg_bit   = 1'b0;
  endtask

  // Called right after the last handshake edge: COMMIT cycle, then the commit edge.
  task automatic finish_load(input string tag, input logic [0:63] pat, input logic [0:63] prev);
    check({tag, "_commit_done"},  64'(u_if.cfg_done),  64'd0);
    check({tag, "_commit_ready"}, 64'(u_if.cfg_ready), 64'd0);
    check({tag, "_commit_sram"},  u_if.sram, prev);
    tick();
    check({tag, "_done"},     64'(u_if.cfg_done), 64'd1);
    check({tag, "_sram"},     u_if.sram, pat);
    check({tag, "_sram_inv"}, u_if.sram_inv, ~pat);
  endtask

  initial begin
    logic [0:63] tails;
    logic [0:63] pat_a;
    logic [0:63] pat_b;
    logic [0:63] pat_c;
    checks = 0;
    errors = 0;
    cyc    = 0;
    pat_a  = 64'h0123_4567_89AB_CDEF;
    pat_b  = 64'hF0E1_D2C3_B4A5_9687;
    pat_c  = 64'h5A5A_0FF0_C3C3_1234;
    rst            = 1'b1;
    u_if.cfg_start = 1'b0;
    u_if.cfg_valid = 1'b0;
    u_if.cfg_bit   = 1'b0;

    // 1. Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_sram",     u_if.sram, 64'h0);
    check("rst_sram_inv", u_if.sram_inv, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_ready",    64'(u_if.cfg_ready), 64'd0);
    check("rst_done",     64'(u_if.cfg_done), 64'd0);
    check("rst_err",      64'(u_if.cfg_err), 64'd0);
    check("rst_tail",     64'(u_if.ccff_tail), 64'd0);

    // Stream ignored while idle
    u_if.cfg_valid = 1'b1;
    u_if.cfg_bit   = 1'b1;
    tick();
    tick();
    u_if.cfg_valid = 1'b0;
    check("idle_ready", 64'(u_if.cfg_ready), 64'd0);
    check("idle_sram",  u_if.sram, 64'h0);

    // 2. AND6
    pulse_start();
    check("and6_ready", 64'(u_if.cfg_ready), 64'd1);
    send_bits(64'h1, 64, 1'b0, tails);
    finish_load("and6", 64'h1, 64'h0);

    // Stream ignored in DONE
    u_if.cfg_valid = 1'b1;
    u_if.cfg_bit   = 1'b1;
    tick();
    tick();
    tick();
    u_if.cfg_valid = 1'b0;
    check("done_hold_sram", u_if.sram, 64'h1);
    check("done_hold_done", 64'(u_if.cfg_done), 64'd1);
    check("done_ready",     64'(u_if.cfg_ready), 64'd0);

    // 3. Backpressure, alternating pattern
    pulse_start();
    check("bp_start_done", 64'(u_if.cfg_done), 64'd0);
    send_bits(64'hAAAA_AAAA_AAAA_AAAA, 64, 1'b1, tails);
    check("bp_tails", tails, 64'h1);
    finish_load("bp", 64'hAAAA_AAAA_AAAA_AAAA, 64'h1);

    // 4. Abort after 20 bits, restart with all ones
    pulse_start();
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20, 1'b0, tails);
    u_if.cfg_start = 1'b1;
    u_if.cfg_valid = 1'b1;
    u_if.cfg_bit   = 1'b0;
    tick();
    u_if.cfg_start = 1'b0;
    u_if.cfg_valid = 1'b0;
    check("abort_err",   64'(u_if.cfg_err), 64'd1);
    check("abort_ready", 64'(u_if.cfg_ready), 64'd1);
    check("abort_sram",  u_if.sram, 64'hAAAA_AAAA_AAAA_AAAA);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, tails);
    check("abort_err_hold", 64'(u_if.cfg_err), 64'd1);
    finish_load("abort", 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA);
    check("abort_err_after", 64'(u_if.cfg_err), 64'd1);

    // 5. Chaining: A then B, tail reproduces A
    pulse_start();
    check("chain_err_clr", 64'(u_if.cfg_err), 64'd0);
    send_bits(pat_a, 64, 1'b0, tails);
    finish_load("chain_a", pat_a, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse_start();
    send_bits(pat_b, 64, 1'b1, tails);
    check("chain_tails", tails, pat_a);
    finish_load("chain_b", pat_b, pat_a);

    // 6. Reset after 40 bits, then clean load
    pulse_start();
    send_bits(pat_c, 40, 1'b0, tails);
    rst            = 1'b1;
    u_if.cfg_valid = 1'b1;
    u_if.cfg_start = 1'b1;
    tick();
    rst            = 1'b0;
    u_if.cfg_valid = 1'b0;
    u_if.cfg_start = 1'b0;
    check("mrst_sram",     u_if.sram, 64'h0);
    check("mrst_sram_inv", u_if.sram_inv, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mrst_ready",    64'(u_if.cfg_ready), 64'd0);
    check("mrst_done",     64'(u_if.cfg_done), 64'd0);
    check("mrst_err",      64'(u_if.cfg_err), 64'd0);
    check("mrst_tail",     64'(u_if.ccff_tail), 64'd0);
    pulse_start();
    send_bits(pat_c, 64, 1'b0, tails);
    check("mrst_chain_tails", tails, 64'h0);
    finish_load("mrst_load", pat_c, 64'h0);
    check("mrst_load_err", 64'(u_if.cfg_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
